// File: rtl/hud_number_display_if.sv
// Bundles the frame/value/pixel inputs and the sprite outputs of the HUD digit block.
// Latency: none, wiring only.
// Backpressure: none, all signals are sampled or produced every cycle.
interface hud_number_display_if #(
  parameter int VALUE_W = 10,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 15
);
  logic               frame_start;
  logic [VALUE_W-1:0] Value;
  logic [COORD_W-1:0] PixelX;
  logic [COORD_W-1:0] PixelY;
  logic               is_obj;
  logic [ADDR_W-1:0]  Obj_address;
  logic               busy;

  // Frame/pixel source side
  modport master (
    output frame_start, Value, PixelX, PixelY,
    input  is_obj, Obj_address, busy
  );

  // HUD digit block side
  modport slave (
    input  frame_start, Value, PixelX, PixelY,
    output is_obj, Obj_address, busy
  );
endinterface

// File: rtl/hud_number_display.sv
// Multi-digit HUD number: per-frame sample, serial double-dabble BCD, blanking, blink-on-drop, sprite address.
// Latency: commit VALUE_W clocks after frame_start; is_obj/Obj_address registered 1 clock after PixelX/PixelY.
// Backpressure: none; frame_start arriving during a conversion is ignored for conversion.
module hud_number_display #(
  parameter int NUM_DIGITS   = 3,
  parameter int VALUE_W      = 10,
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 46,
  parameter int GAP          = 0,
  parameter int X_POS        = 100,
  parameter int Y_POS        = 5,
  parameter int COORD_W      = 10,
  parameter int ADDR_W       = 15,
  parameter int FLASH_FRAMES = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  hud_number_display_if.slave  bus
);

  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam int CNT_W    = $clog2(VALUE_W + 1);
  localparam int FLASH_WR = $clog2(FLASH_FRAMES + 1);
  // At least two bits so the blink phase bit always exists.
  localparam int FLASH_W  = (FLASH_WR < 2) ? 2 : FLASH_WR;
  localparam logic [31:0] MAX_V = 32'(10 ** NUM_DIGITS - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_CONVERT = 1'b1;

  logic [0:0]         state;
  logic [CNT_W-1:0]   iter_cnt;
  logic [VALUE_W-1:0] v_sat;
  logic [VALUE_W-1:0] v_shift;
  logic [VALUE_W-1:0] v_latched;
  logic [VALUE_W-1:0] prev_value;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [BCD_W-1:0]   shown_bcd;
  logic [FLASH_W-1:0] flash_cnt;
  logic               commit;
  logic               flash_hide;

  logic [31:0]        px;
  logic [31:0]        py;
  logic [31:0]        x0;
  logic [3:0]         dig;
  logic               lead_zero;
  logic               in_y;
  logic               hit;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               is_obj_q;
  logic [ADDR_W-1:0]  obj_address_q;

  // Clamp the sampled value to the largest number the digits can show (all nines).
  always_comb begin
    v_sat = bus.Value;
    if (32'(bus.Value) > MAX_V) begin
      v_sat = MAX_V[VALUE_W-1:0];
    end
  end

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next value bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[BCD_W-2:0], v_shift[VALUE_W-1]};
  end

  // The last conversion step is the only edge on which shown digits may change.
  assign commit = (state == ST_CONVERT) && (iter_cnt == CNT_W'(1));

  // Conversion FSM; reset mid-conversion drops the partial result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      iter_cnt   <= '0;
      v_shift    <= '0;
      v_latched  <= '0;
      bcd        <= '0;
      shown_bcd  <= '0;
      prev_value <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.frame_start) begin
            state     <= ST_CONVERT;
            v_shift   <= v_sat;
            v_latched <= v_sat;
            bcd       <= '0;
            iter_cnt  <= CNT_W'(VALUE_W);
          end
        end
        ST_CONVERT: begin
          bcd      <= bcd_next;
          v_shift  <= {v_shift[VALUE_W-2:0], 1'b0};
          iter_cnt <= iter_cnt - 1'b1;
          if (commit) begin
            shown_bcd  <= bcd_next;
            prev_value <= v_latched;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == ST_CONVERT);

  // Blink counter: reload on a committed drop, otherwise count down once per frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      flash_cnt <= '0;
    end else if (commit && (v_latched < prev_value)) begin
      flash_cnt <= FLASH_W'(FLASH_FRAMES);
    end else if (bus.frame_start && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign flash_hide = (flash_cnt != '0) && flash_cnt[1];

  // Locate the digit box under the pixel, apply leading-zero blanking and blink, form the address.
  always_comb begin
    px        = 32'(bus.PixelX);
    py        = 32'(bus.PixelY);
    x0        = '0;
    dig       = '0;
    hit       = 1'b0;
    addr_nxt  = '0;
    lead_zero = 1'b1;
    in_y      = (py >= 32'(Y_POS)) && (py < 32'(Y_POS + HEIGHT));
    for (int k = 0; k < NUM_DIGITS; k++) begin
      x0        = 32'(X_POS + k * (WIDTH + GAP));
      dig       = shown_bcd[4*(NUM_DIGITS-1-k) +: 4];
      lead_zero = lead_zero && (dig == 4'd0);
      if (in_y && (px >= x0) && (px < x0 + 32'(WIDTH)) &&
          !(lead_zero && (k < NUM_DIGITS - 1))) begin
        hit      = 1'b1;
        addr_nxt = ADDR_W'(px - x0)
                 + ADDR_W'((py - 32'(Y_POS)) * 32'(WIDTH))
                 + ADDR_W'(dig) * ADDR_W'(WIDTH * HEIGHT);
      end
    end
    if (flash_hide) begin
      hit      = 1'b0;
      addr_nxt = '0;
    end
  end

  // Register the pixel result so it lines up one clock after the coordinates.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      is_obj_q      <= 1'b0;
      obj_address_q <= '0;
    end else begin
      is_obj_q      <= hit;
      obj_address_q <= addr_nxt;
    end
  end

  assign bus.is_obj      = is_obj_q;
  assign bus.Obj_address = obj_address_q;

endmodule
